// File: rtl/group_arr_bbaa2baba_serializer_if.sv
// Handshake bundle for the planar-to-piled serializer: one planar frame in, one piled beat out.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface group_arr_bbaa2baba_serializer_if #(
  parameter int ArrL   = 32,
  parameter int PiledW = 32,
  parameter int IdxW   = $clog2(ArrL)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [PiledW*ArrL-1:0] groupArrBBAA;
  logic                   out_valid;
  logic                   out_ready;
  logic [PiledW-1:0]      out_piled;
  logic [IdxW-1:0]        out_idx;
  logic                   out_last;

  modport slave (
    input  in_valid, groupArrBBAA, out_ready,
    output in_ready, out_valid, out_piled, out_idx, out_last
  );

  modport master (
    output in_valid, groupArrBBAA, out_ready,
    input  in_ready, out_valid, out_piled, out_idx, out_last
  );
endinterface

// File: rtl/group_arr_bbaa2baba_serializer.sv
// Planar (BBAA) group array to element-serial piled (BABA) word stream, one element index per beat.
// Active buffer is serialized while a pending buffer absorbs the next frame, so frames stream without bubbles.
module group_arr_bbaa2baba_serializer #(
  parameter int ArrL      = 32,
  parameter int Arr1EleW  = 8,
  parameter int Arr2EleW  = Arr1EleW,
  parameter int Arr3EleW  = Arr2EleW,
  parameter int Arr4EleW  = Arr3EleW,
  parameter int piledArrW = Arr1EleW + Arr2EleW + Arr3EleW + Arr4EleW,
  parameter int IdxW      = $clog2(ArrL)
) (
  input logic clk,
  input logic rst,
  group_arr_bbaa2baba_serializer_if.slave bus
);

  localparam int FrameW = piledArrW * ArrL;
  localparam int EleW [4] = '{Arr1EleW, Arr2EleW, Arr3EleW, Arr4EleW};
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ArrL - 1);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    SEND      = 2'd1,
    SEND_PEND = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [IdxW-1:0]   idx_q, idx_n;
  logic              last_q, last_n;
  logic [FrameW-1:0] active_buf;
  logic [FrameW-1:0] pend_buf;
  logic              load_in, load_from_pend, load_pend;
  logic              beat;
  logic [piledArrW-1:0] piled_word;

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.in_ready  = (state_q != SEND_PEND);
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_piled = piled_word;
  assign beat          = bus.out_valid && bus.out_ready;

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_n        = state_q;
    idx_n          = idx_q;
    load_in        = 1'b0;
    load_from_pend = 1'b0;
    load_pend      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (bus.in_valid) begin
          load_in = 1'b1;
          state_n = SEND;
          idx_n   = '0;
        end
      end
      SEND: begin
        if (beat && last_q) begin
          // Last beat with pending empty: an offered frame loads straight into active.
          idx_n = '0;
          if (bus.in_valid) begin
            load_in = 1'b1;
          end else begin
            state_n = EMPTY;
          end
        end else begin
          if (beat) begin
            idx_n = idx_q + 1'b1;
          end
          if (bus.in_valid) begin
            load_pend = 1'b1;
            state_n   = SEND_PEND;
          end
        end
      end
      SEND_PEND: begin
        if (beat && last_q) begin
          load_from_pend = 1'b1;
          state_n        = SEND;
          idx_n          = '0;
        end else if (beat) begin
          idx_n = idx_q + 1'b1;
        end
      end
      default: begin
        state_n = EMPTY;
        idx_n   = '0;
      end
    endcase
    last_n = (state_n != EMPTY) && (idx_n == LastIdx);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: active_buf is reset because out_piled is read straight from it and must be zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      idx_q      <= '0;
      last_q     <= 1'b0;
      active_buf <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      if (load_in) begin
        active_buf <= bus.groupArrBBAA;
      end else if (load_from_pend) begin
        active_buf <= pend_buf;
      end
    end
  end

  // Pending contents are only meaningful while the FSM says so, hence no reset on this storage.
  always_ff @(posedge clk) begin
    if (load_pend) begin
      pend_buf <= bus.groupArrBBAA;
    end
  end

  // Each present sub-array contributes one field; absent (zero-width) ones produce nothing.
  for (genvar k = 0; k < 4; k++) begin : g_field
    localparam int W     = EleW[k];
    localparam int Off   = (k > 0 ? EleW[0] : 0) + (k > 1 ? EleW[1] : 0) + (k > 2 ? EleW[2] : 0);
    localparam int Start = Off * ArrL;
    if (W > 0) begin : g_on
      logic [W-1:0] ele [ArrL];
      for (genvar i = 0; i < ArrL; i++) begin : g_ele
        assign ele[i] = active_buf[Start + i*W +: W];
      end
      assign piled_word[Off +: W] = ele[idx_q];
    end
  end

endmodule
